vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL provide parameter H_FP, default 16, horizontal front porch (pixels).
REQ-003 SHALL provide parameter H_SYNC, default 96, horizontal sync width (pixels).
REQ-004 SHALL provide parameter H_BP, default 48, horizontal back porch (pixels); H_TOTAL = sum = 800.
REQ-005 SHALL provide parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (lines); V_TOTAL = 525.
REQ-006 clk  input  1  single clock, rising edge; one pixel per cycle.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 ena  input  1  advance enable; low freezes all state and outputs.
REQ-009 hsync  output  1  horizontal sync, active-low.
REQ-010 vsync  output  1  vertical sync, active-low.
REQ-011 display_on  output  1  high when current position is in the visible area.
REQ-012 hpos  output  10  current pixel column, 0..H_TOTAL-1.
REQ-013 vpos  output  10  current line, 0..V_TOTAL-1.
REQ-014 line_end  output  1  high while hpos == H_TOTAL-1.
REQ-015 frame_end  output  1  high while hpos == H_TOTAL-1 and vpos == V_TOTAL-1.
REQ-016 frame  output  8  frame count driving the downstream rings renderer's animation.

Function
REQ-017 All outputs SHALL be registered and SHALL describe the same (hpos, vpos) in the same cycle; zero-cycle skew between position and flags.
REQ-018 With ena=1, hpos SHALL increment by 1 per cycle and wrap H_TOTAL-1 -> 0.
REQ-019 vpos SHALL increment only in the cycle hpos wraps; wraps V_TOTAL-1 -> 0 on the same edge.
REQ-020 hsync SHALL be 0 iff H_ACTIVE+H_FP <= hpos <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 default).
REQ-021 vsync SHALL be 0 iff V_ACTIVE+V_FP <= vpos <= V_ACTIVE+V_FP+V_SYNC-1 (490..491 default), for the whole line.
REQ-022 display_on SHALL be 1 iff hpos < H_ACTIVE and vpos < V_ACTIVE.
REQ-023 frame SHALL increment by 1 on the edge where (hpos, vpos) wraps to (0,0); 8-bit wrap 255 -> 0.
REQ-024 With ena=0, hpos, vpos, frame and all flags SHALL hold their values; line_end/frame_end SHALL remain at their held level (not re-pulse).
REQ-025 Counter arithmetic SHALL be unsigned, 10-bit, compared against parameter-derived constants; no out-of-range value reachable.

Reset
REQ-026 rst SHALL take priority over ena.
REQ-027 On a clock edge with rst=1: hpos=0, vpos=0, frame=0, hsync=1, vsync=1, display_on=1, line_end=0, frame_end=0.
REQ-028 Reset asserted mid-frame SHALL restart at (0,0) on the next edge with no partial sync pulse retained; first advance occurs on the first edge with rst=0 and ena=1.

Configuration
REQ-029 Macro VGA_FRAME_COUNTER_EN defined: frame counter SHALL be implemented per REQ-023.
REQ-030 Macro VGA_FRAME_COUNTER_EN undefined: frame SHALL be constant 0 and no frame-counter flops SHALL exist; all other behaviour unchanged.

Structure
REQ-031 Package vga_timing_pkg SHALL hold default timing constants, H_TOTAL/V_TOTAL derivation and POS_W = 10 width constant.
REQ-032 One sub-module vga_wrap_counter (parameterized modulus, enable, wrap pulse) SHALL be instantiated for hpos and vpos.

Verification
REQ-033 Reset, ena=1, 800 cycles -> hpos 0..799, hsync=0 exactly at hpos 656..751, line_end=1 only at 799, then vpos=1, hpos=0.
REQ-034 Run 420000 cycles -> vsync=0 for exactly 1600 cycles (vpos 490..491), frame_end=1 exactly once, ends at (0,0) with frame=1.
REQ-035 At (100, 5) drop ena for 10 cycles -> hpos stays 100, vpos stays 5, all flags frozen; hpos=101 on first edge after ena=1.
REQ-036 At (300, 200), frame=3, assert rst with ena=0 -> next edge (0,0), hsync=vsync=1, display_on=1, frame=0.
REQ-037 Boundary positions -> display_on=1 at (639,479), 0 at (640,479), 0 at (0,480), 1 at (0,0).
REQ-038 256 frames with VGA_FRAME_COUNTER_EN -> frame wraps 255 -> 0; without macro -> frame reads 0 throughout.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Default 640x480@60 timing constants, total derivation and the
//             common position / frame counter widths.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int POS_W   = 10;
    localparam int FRAME_W = 8;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // One axis is active + front porch + sync + back porch.
    function automatic int span_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Purpose  : Timing bus between the VGA timing generator (master) and the
//             downstream renderer (slave). The slave owns the advance enable.
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic               ena;
    logic               hsync;
    logic               vsync;
    logic               display_on;
    logic [POS_W-1:0]   hpos;
    logic [POS_W-1:0]   vpos;
    logic               line_end;
    logic               frame_end;
    logic [FRAME_W-1:0] frame;

    modport master (
        input  ena,
        output hsync, vsync, display_on, hpos, vpos, line_end, frame_end, frame
    );

    modport slave (
        output ena,
        input  hsync, vsync, display_on, hpos, vpos, line_end, frame_end, frame
    );

endinterface
`default_nettype wire

// File: rtl/vga_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_wrap_counter
//  Purpose  : Modulo-MODULUS up counter with enable. Exposes the registered
//             count, the value it will take on the next edge, and a wrap
//             pulse that is high in the cycle the count rolls over to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int MODULUS = H_TOTAL_DEF,
    parameter int WIDTH   = POS_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_ena,
    output logic      [WIDTH-1:0] o_count,
    output logic      [WIDTH-1:0] o_count_nxt,
    output logic                  o_wrap
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_at_last;

    assign w_at_last = (r_count == c_last);

    // Next value: hold when disabled, roll over from the last value to 0.
    always_comb begin
        w_count_nxt = r_count;
        if (i_ena) begin
            w_count_nxt = w_at_last ? '0 : r_count + 1'b1;
        end
    end

    // Count register; reset restarts the axis at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;
    assign o_wrap      = i_ena & w_at_last;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster timing generator. Produces pixel position, active-low
//             syncs, visible-area flag, line/frame end flags and a frame count.
//             Every output is a register decoded from the position the
//             counters move to, so flags and position never skew.
//  Config   : VGA_FRAME_COUNTER_EN - when defined, an 8-bit frame counter
//             advances on every (0,0) wrap; otherwise frame reads constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vga_timing_gen_if.master  vga
);

    localparam int c_h_total = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [POS_W-1:0] c_h_active   = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] c_hs_start   = POS_W'(H_ACTIVE + H_FP);
    localparam logic [POS_W-1:0] c_hs_end     = POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [POS_W-1:0] c_h_last     = POS_W'(c_h_total - 1);
    localparam logic [POS_W-1:0] c_v_active   = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] c_vs_start   = POS_W'(V_ACTIVE + V_FP);
    localparam logic [POS_W-1:0] c_vs_end     = POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [POS_W-1:0] c_v_last     = POS_W'(c_v_total - 1);

    logic [POS_W-1:0] w_hpos;
    logic [POS_W-1:0] w_vpos;
    logic [POS_W-1:0] w_hpos_nxt;
    logic [POS_W-1:0] w_vpos_nxt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_v_ena;

    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_display_nxt;
    logic             w_line_end_nxt;
    logic             w_frame_end_nxt;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_display_on;
    logic             r_line_end;
    logic             r_frame_end;

    // The line counter only steps in the cycle the pixel counter rolls over.
    assign w_v_ena = w_h_wrap;

    vga_wrap_counter #(
        .MODULUS (c_h_total),
        .WIDTH   (POS_W)
    ) u_hcnt (
        .clk         (clk),
        .rst         (rst),
        .i_ena       (vga.ena),
        .o_count     (w_hpos),
        .o_count_nxt (w_hpos_nxt),
        .o_wrap      (w_h_wrap)
    );

    vga_wrap_counter #(
        .MODULUS (c_v_total),
        .WIDTH   (POS_W)
    ) u_vcnt (
        .clk         (clk),
        .rst         (rst),
        .i_ena       (w_v_ena),
        .o_count     (w_vpos),
        .o_count_nxt (w_vpos_nxt),
        .o_wrap      (w_v_wrap)
    );

    // Decode flags from the upcoming position; when ena is low the upcoming
    // position equals the current one, so every flag holds its level.
    always_comb begin
        w_hsync_nxt     = !((w_hpos_nxt >= c_hs_start) && (w_hpos_nxt <= c_hs_end));
        w_vsync_nxt     = !((w_vpos_nxt >= c_vs_start) && (w_vpos_nxt <= c_vs_end));
        w_display_nxt   = (w_hpos_nxt < c_h_active) && (w_vpos_nxt < c_v_active);
        w_line_end_nxt  = (w_hpos_nxt == c_h_last);
        w_frame_end_nxt = (w_hpos_nxt == c_h_last) && (w_vpos_nxt == c_v_last);
    end

    // Flag registers, aligned with the position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_display_on <= 1'b1;
            r_line_end   <= 1'b0;
            r_frame_end  <= 1'b0;
        end else begin
            r_hsync      <= w_hsync_nxt;
            r_vsync      <= w_vsync_nxt;
            r_display_on <= w_display_nxt;
            r_line_end   <= w_line_end_nxt;
            r_frame_end  <= w_frame_end_nxt;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [FRAME_W-1:0] r_frame;

    // Frame count steps on the edge where (hpos, vpos) returns to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame <= '0;
        end else if (w_v_wrap) begin
            r_frame <= r_frame + 1'b1;
        end
    end

    assign vga.frame = r_frame;
`else
    logic w_unused_v_wrap;

    assign w_unused_v_wrap = w_v_wrap;
    assign vga.frame       = '0;
`endif

    assign vga.hpos       = w_hpos;
    assign vga.vpos       = w_vpos;
    assign vga.hsync      = r_hsync;
    assign vga.vsync      = r_vsync;
    assign vga.display_on = r_display_on;
    assign vga.line_end   = r_line_end;
    assign vga.frame_end  = r_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Scoreboard bench for vga_timing_gen using a reduced raster
//             (16 x 12) so whole frames and the 8-bit frame wrap fit in a
//             short run. The model tracks a linear pixel index per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int HA = 10, HF = 2, HS = 2, HB = 2;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_LEN = HT * VT;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       disp;
        logic       le;
        logic       fe;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic [7:0] frame;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_gen_if vga ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vga)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   n_hs_low = 0, n_vs_low = 0, n_le = 0, n_fe = 0;

    // Reference model: linear index within the frame plus a frame number.
    int unsigned m_t = 0;
    int unsigned m_frame = 0;

    function automatic obs_t model_obs();
        obs_t o;
        int unsigned h, v;
        h = m_t % HT;
        v = m_t / HT;
        o.hpos  = 10'(h);
        o.vpos  = 10'(v);
        o.hsync = !(h >= HA + HF && h < HA + HF + HS);
        o.vsync = !(v >= VA + VF && v < VA + VF + VS);
        o.disp  = (h < HA) && (v < VA);
        o.le    = (h == HT - 1);
        o.fe    = (m_t == FRAME_LEN - 1);
        o.frame = 8'(m_frame);
        return o;
    endfunction

    task automatic model_update(input logic r, input logic e);
        if (r) begin
            m_t     = 0;
            m_frame = 0;
        end else if (e) begin
            m_t = m_t + 1;
            if (m_t == FRAME_LEN) begin
                m_t = 0;
`ifdef VGA_FRAME_COUNTER_EN
                m_frame = (m_frame + 1) % 256;
`endif
            end
        end
    endtask

    // One clock: drive inputs, predict the post-edge outputs, queue them.
    task automatic step(input logic r, input logic e);
        rst     = r;
        vga.ena = e;
        @(posedge clk);
        model_update(r, e);
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    task automatic drain();
        #1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_cnt(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_mis++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic goto_pos(input int h, input int v);
        step(1'b1, 1'b0);
        for (int i = 0; i < FRAME_LEN && m_t != v * HT + h; i++) step(1'b0, 1'b1);
    endtask

    // Monitor: compare every presented output cycle against the queue head.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{hsync: vga.hsync, vsync: vga.vsync, disp: vga.display_on,
                      le: vga.line_end, fe: vga.frame_end, hpos: vga.hpos,
                      vpos: vga.vpos, frame: vga.frame};
                n_vec++;
                if (a !== e) begin
                    n_mis++;
                    $display("FAIL scoreboard @%0t: got h=%0d v=%0d hs=%b vs=%b de=%b le=%b fe=%b fr=%0d, required h=%0d v=%0d hs=%b vs=%b de=%b le=%b fe=%b fr=%0d",
                             $time, a.hpos, a.vpos, a.hsync, a.vsync, a.disp, a.le, a.fe, a.frame,
                             e.hpos, e.vpos, e.hsync, e.vsync, e.disp, e.le, e.fe, e.frame);
                end
                if (a.hsync === 1'b0) n_hs_low++;
                if (a.vsync === 1'b0) n_vs_low++;
                if (a.le === 1'b1)    n_le++;
                if (a.fe === 1'b1)    n_fe++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, vs0, le0, fe0;
        vga.ena = 1'b0;

        // Reset state.
        repeat (3) step(1'b1, 1'b1);
        drain();

        // One full line from (0,0).
        hs0 = n_hs_low; le0 = n_le;
        repeat (HT) step(1'b0, 1'b1);
        drain();
        check_cnt("line_hsync_low", n_hs_low - hs0, HS);
        check_cnt("line_end_count", n_le - le0, 1);

        // Randomized enable with occasional reset.
        repeat (3000) step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));
        drain();

        // Freeze mid-frame, then resume.
        goto_pos(5, 3);
        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Reset with ena low after a few frames, mid-frame.
        goto_pos(0, 0);
        repeat (3 * FRAME_LEN + 6 * HT + 7) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        drain();

        // Visible-area boundaries.
        goto_pos(HA - 1, VA - 1);
        step(1'b0, 1'b1);
        goto_pos(0, VA);
        drain();

        // One whole frame, then enough frames to wrap the 8-bit counter.
        step(1'b1, 1'b0);
        drain();
        hs0 = n_hs_low; vs0 = n_vs_low; fe0 = n_fe;
        repeat (FRAME_LEN) step(1'b0, 1'b1);
        drain();
        check_cnt("frame_vsync_low", n_vs_low - vs0, VS * HT);
        check_cnt("frame_hsync_low", n_hs_low - hs0, HS * VT);
        check_cnt("frame_end_count", n_fe - fe0, 1);
        repeat (256 * FRAME_LEN) step(1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
